// File: rtl/gfx_pkg.sv
// gfx_pkg: definitions shared by the guitar effect sequencer files.
//   - Avalon-MM register addresses of the effect register block
//   - STATUS_DONE_BIT: STATUS bit that flags a finished sample
//   - gfx_state_e: sequencer FSM states
package gfx_pkg;

  localparam int AVM_ADDR_W = 5;

  localparam logic [AVM_ADDR_W-1:0] ADDR_GAIN   = 5'd1;
  localparam logic [AVM_ADDR_W-1:0] ADDR_BOOST  = 5'd2;
  localparam logic [AVM_ADDR_W-1:0] ADDR_STATUS = 5'd3;
  localparam logic [AVM_ADDR_W-1:0] ADDR_OUTPUT = 5'd5;
  localparam logic [AVM_ADDR_W-1:0] ADDR_INPUT  = 5'd6;

  localparam int STATUS_DONE_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_GAIN,
    ST_CFG_BOOST,
    ST_WR_IN,
    ST_RD_STAT,
    ST_WAIT_STAT,
    ST_RD_OUT,
    ST_WAIT_OUT,
    ST_PUSH
  } gfx_state_e;

endpackage

// File: rtl/gfx_effect_sequencer_if.sv
// gfx_effect_sequencer_if: sample streams and Avalon-MM master bus of the
// effect sequencer.
//   smp_in_*   : input sample ready/valid stream (signed samples)
//   smp_out_*  : processed sample ready/valid stream
//   avm_*      : Avalon-MM master towards the effect register block
// Modports: master = sequencer side, slave = codec/effect side.
interface gfx_effect_sequencer_if #(
  parameter int SAMPLE_W = 16
);
  import gfx_pkg::*;

  logic                       smp_in_valid;
  logic                       smp_in_ready;
  logic signed [SAMPLE_W-1:0] smp_in_data;

  logic                       smp_out_valid;
  logic                       smp_out_ready;
  logic        [SAMPLE_W-1:0] smp_out_data;

  logic [AVM_ADDR_W-1:0]      avm_address;
  logic                       avm_write;
  logic                       avm_read;
  logic [31:0]                avm_writedata;
  logic [31:0]                avm_readdata;

  modport master (
    input  smp_in_valid, smp_in_data, smp_out_ready, avm_readdata,
    output smp_in_ready, smp_out_valid, smp_out_data,
           avm_address, avm_write, avm_read, avm_writedata
  );

  modport slave (
    output smp_in_valid, smp_in_data, smp_out_ready, avm_readdata,
    input  smp_in_ready, smp_out_valid, smp_out_data,
           avm_address, avm_write, avm_read, avm_writedata
  );

endinterface

// File: rtl/gfx_poll_counter.sv
// gfx_poll_counter: counts STATUS polls of the current sample.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : return the count to zero (has priority over inc)
//   inc        : count one more unsuccessful poll
//   at_last    : one more increment makes the count reach POLL_LIMIT
module gfx_poll_counter #(
  parameter int POLL_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/gfx_effect_sequencer.sv
// gfx_effect_sequencer: per-sample Avalon-MM master for the guitar effect.
// Writes each input sample to INPUT, polls STATUS until done, reads OUTPUT
// and streams the result out. Gain/boost updates are shadowed and written
// only between samples.
//   clk, reset     : clock, asynchronous active-low reset
//   bus            : sample streams + Avalon-MM master (interface, master)
//   cfg_update     : pulse, latch cfg_gain / cfg_boost into shadows
//   cfg_gain/boost : new gain / boost values
//   err_clr        : clears timeout_err
//   bypass         : only with GFX_SEQ_BYPASS_EN; route samples around
//                    the effect without bus access
//   busy           : FSM not in IDLE
//   timeout_err    : sticky, STATUS never reported done within POLL_LIMIT
// Build option: define GFX_SEQ_BYPASS_EN to add the bypass port.
module gfx_effect_sequencer
  import gfx_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  gfx_effect_sequencer_if.master bus,
  input  logic        cfg_update,
  input  logic [31:0] cfg_gain,
  input  logic [31:0] cfg_boost,
  input  logic        err_clr,
`ifdef GFX_SEQ_BYPASS_EN
  input  logic        bypass,
`endif
  output logic        busy,
  output logic        timeout_err
);

  function automatic logic [31:0] sign_ext(input logic signed [SAMPLE_W-1:0] s);
    return 32'(s);
  endfunction

  gfx_state_e            state_q, state_d;
  logic [AVM_ADDR_W-1:0] avm_address_q, avm_address_d;
  logic                  avm_write_q, avm_write_d;
  logic                  avm_read_q, avm_read_d;
  logic [31:0]           avm_writedata_q, avm_writedata_d;
  logic                  smp_in_ready_q, smp_in_ready_d;
  logic                  smp_out_valid_q, smp_out_valid_d;
  logic [SAMPLE_W-1:0]   smp_out_data_q, smp_out_data_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [31:0]           gain_sh_q, gain_sh_d;
  logic [31:0]           boost_sh_q, boost_sh_d;
  logic                  cfg_pending_q, cfg_pending_d;

  logic cnt_clr, cnt_inc, cnt_at_last, timeout_set;
  logic unused_rd_hi;

  assign unused_rd_hi = ^bus.avm_readdata[31:SAMPLE_W];

  gfx_poll_counter #(.POLL_LIMIT(POLL_LIMIT)) u_poll_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .at_last (cnt_at_last)
  );

  always_comb begin
    state_d         = state_q;
    avm_address_d   = avm_address_q;
    avm_write_d     = 1'b0;
    avm_read_d      = 1'b0;
    avm_writedata_d = avm_writedata_q;
    smp_out_valid_d = smp_out_valid_q;
    smp_out_data_d  = smp_out_data_q;
    cfg_pending_d   = cfg_pending_q;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    timeout_set     = 1'b0;

    // Shadows resolve first so a config write issued this cycle already
    // carries a same-cycle update (latest value wins).
    gain_sh_d  = cfg_update ? cfg_gain  : gain_sh_q;
    boost_sh_d = cfg_update ? cfg_boost : boost_sh_q;

    // Outputs are registered: strobes/address are set up on the transition
    // into the state that owns the bus cycle.
    case (state_q)
      ST_IDLE: begin
        if (cfg_pending_q) begin
          state_d         = ST_CFG_GAIN;
          avm_write_d     = 1'b1;
          avm_address_d   = ADDR_GAIN;
          avm_writedata_d = gain_sh_d;
        end else if (bus.smp_in_valid && smp_in_ready_q) begin
          cnt_clr = 1'b1;
`ifdef GFX_SEQ_BYPASS_EN
          if (bypass) begin
            state_d         = ST_PUSH;
            smp_out_valid_d = 1'b1;
            smp_out_data_d  = bus.smp_in_data;
          end else
`endif
          begin
            state_d         = ST_WR_IN;
            avm_write_d     = 1'b1;
            avm_address_d   = ADDR_INPUT;
            avm_writedata_d = sign_ext(bus.smp_in_data);
          end
        end
      end
      ST_CFG_GAIN: begin
        state_d         = ST_CFG_BOOST;
        avm_write_d     = 1'b1;
        avm_address_d   = ADDR_BOOST;
        avm_writedata_d = boost_sh_d;
      end
      ST_CFG_BOOST: begin
        state_d       = ST_IDLE;
        cfg_pending_d = 1'b0;
      end
      ST_WR_IN: begin
        state_d       = ST_RD_STAT;
        avm_read_d    = 1'b1;
        avm_address_d = ADDR_STATUS;
      end
      ST_RD_STAT: state_d = ST_WAIT_STAT;
      ST_WAIT_STAT: begin
        if (bus.avm_readdata[STATUS_DONE_BIT]) begin
          state_d       = ST_RD_OUT;
          avm_read_d    = 1'b1;
          avm_address_d = ADDR_OUTPUT;
          cnt_clr       = 1'b1;
        end else if (cnt_at_last) begin
          state_d     = ST_IDLE;
          timeout_set = 1'b1;
          cnt_clr     = 1'b1;
        end else begin
          state_d       = ST_RD_STAT;
          avm_read_d    = 1'b1;
          avm_address_d = ADDR_STATUS;
          cnt_inc       = 1'b1;
        end
      end
      ST_RD_OUT: state_d = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        state_d         = ST_PUSH;
        smp_out_valid_d = 1'b1;
        smp_out_data_d  = bus.avm_readdata[SAMPLE_W-1:0];
      end
      ST_PUSH: begin
        if (bus.smp_out_ready) begin
          state_d         = ST_IDLE;
          smp_out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pulse in any state (including CFG_BOOST) leaves an update pending.
    if (cfg_update) cfg_pending_d = 1'b1;

    if (timeout_set)  timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
    else              timeout_err_d = timeout_err_q;

    busy_d         = (state_d != ST_IDLE);
    smp_in_ready_d = (state_d == ST_IDLE) && !cfg_pending_d;
  end

  // State / registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      avm_address_q   <= '0;
      avm_write_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_writedata_q <= '0;
      smp_in_ready_q  <= 1'b0;
      smp_out_valid_q <= 1'b0;
      smp_out_data_q  <= '0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      gain_sh_q       <= '0;
      boost_sh_q      <= '0;
      cfg_pending_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      avm_address_q   <= avm_address_d;
      avm_write_q     <= avm_write_d;
      avm_read_q      <= avm_read_d;
      avm_writedata_q <= avm_writedata_d;
      smp_in_ready_q  <= smp_in_ready_d;
      smp_out_valid_q <= smp_out_valid_d;
      smp_out_data_q  <= smp_out_data_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
      gain_sh_q       <= gain_sh_d;
      boost_sh_q      <= boost_sh_d;
      cfg_pending_q   <= cfg_pending_d;
    end
  end

  assign bus.avm_address   = avm_address_q;
  assign bus.avm_write     = avm_write_q;
  assign bus.avm_read      = avm_read_q;
  assign bus.avm_writedata = avm_writedata_q;
  assign bus.smp_in_ready  = smp_in_ready_q;
  assign bus.smp_out_valid = smp_out_valid_q;
  assign bus.smp_out_data  = smp_out_data_q;
  assign busy              = busy_q;
  assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_gfx_effect_sequencer.sv
// Testbench for gfx_effect_sequencer: directed vector table for sample
// transactions plus hand-written sequences for timeout, configuration,
// backpressure, reset and (with GFX_SEQ_BYPASS_EN) bypass.
module tb_gfx_effect_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_update = 1'b0;
  logic [31:0] cfg_gain = '0;
  logic [31:0] cfg_boost = '0;
  logic        err_clr = 1'b0;
  logic        busy, timeout_err;
`ifdef GFX_SEQ_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  // Effect register block model
  int          done_after = 1;
  int          poll_cnt = 0;
  int          stat_reads = 0;
  logic [31:0] out_word = '0;
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  gfx_effect_sequencer_if #(.SAMPLE_W(16)) bus ();

  gfx_effect_sequencer #(.SAMPLE_W(16), .POLL_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cfg_update  (cfg_update),
    .cfg_gain    (cfg_gain),
    .cfg_boost   (cfg_boost),
    .err_clr     (err_clr),
`ifdef GFX_SEQ_BYPASS_EN
    .bypass      (bypass),
`endif
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.avm_write) begin
      wr_addr.push_back(bus.avm_address);
      wr_data.push_back(bus.avm_writedata);
      wr_cyc.push_back(cyc);
      if (bus.avm_address == 5'd6) poll_cnt <= 0;
    end
    if (bus.avm_read) begin
      if (bus.avm_address == 5'd3) begin
        stat_reads <= stat_reads + 1;
        poll_cnt   <= poll_cnt + 1;
        bus.avm_readdata <= (poll_cnt + 1 >= done_after) ? 32'h0000_0001 : 32'hFFFF_FFFE;
      end else if (bus.avm_address == 5'd5) begin
        bus.avm_readdata <= out_word;
      end else begin
        bus.avm_readdata <= '0;
      end
    end
  end

  typedef struct {
    logic [15:0] smp;
    int          polls;
    logic [31:0] out_word;
    logic [31:0] exp_wdata;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, busy, timeout_err, bus.smp_in_ready, bus.smp_out_valid,
            bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata,
            bus.smp_out_data};
  endfunction

  // Present a sample and return just after the accepting edge.
  task automatic send(input logic [15:0] s);
    int k;
    @(negedge clk);
    bus.smp_in_valid = 1'b1;
    bus.smp_in_data  = s;
    k = 0;
    while (!bus.smp_in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", {63'd0, bus.smp_in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.smp_in_valid = 1'b0;
  endtask

  // Cycles from acceptance until smp_out_valid is seen (sampled at negedge).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.smp_out_valid && lat < 60);
    if (!bus.smp_out_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL out_valid_wait: no smp_out_valid within %0d cycles", lat);
    end
  endtask

  initial begin
    int lat, wb, sb, k;
    logic seen, stable;
    logic [15:0] held;

    vecs[0] = '{16'h8001, 1, 32'h1234_ABCD, 32'hFFFF_8001, 16'hABCD, 6};
    vecs[1] = '{16'h7FFF, 3, 32'h0000_5555, 32'h0000_7FFF, 16'h5555, 10};
    vecs[2] = '{16'h0000, 2, 32'hFFFF_0000, 32'h0000_0000, 16'h0000, 8};
    vecs[3] = '{16'hFFFF, 1, 32'h0000_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 6};

    bus.smp_in_valid  = 1'b0;
    bus.smp_in_data   = '0;
    bus.smp_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, bus.smp_in_ready}, 64'd1);

    // Vector table: sample transactions with varying poll counts
    for (int i = 0; i < 4; i++) begin
      done_after = vecs[i].polls;
      out_word   = vecs[i].out_word;
      wb = wr_addr.size();
      sb = stat_reads;
      send(vecs[i].smp);
      wait_out(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_out_data", i), 64'(bus.smp_out_data), 64'(vecs[i].exp_out));
      chk($sformatf("v%0d_stat_reads", i), 64'(stat_reads - sb), 64'(vecs[i].polls));
      chk($sformatf("v%0d_write_count", i), 64'(wr_addr.size() - wb), 64'd1);
      if (wr_addr.size() > wb)
        chk($sformatf("v%0d_input_write", i), {27'd0, wr_addr[wb], wr_data[wb]},
            {27'd0, 5'd6, vecs[i].exp_wdata});
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", i), {63'd0, bus.smp_out_valid}, 64'd0);
    end

    // Poll timeout: STATUS never done, POLL_LIMIT = 4
    done_after = 1000;
    sb = stat_reads;
    send(16'h0123);
    k = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      k++;
      seen |= bus.smp_out_valid;
    end while (busy && k < 40);
    chk("to_idle_cycle", 64'(k), 64'd10);
    chk("to_stat_reads", 64'(stat_reads - sb), 64'd4);
    chk("to_err_set", {63'd0, timeout_err}, 64'd1);
    chk("to_no_output", {63'd0, seen}, 64'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_clr", {63'd0, timeout_err}, 64'd0);

    // Config updates mid-sample: two pulses, last values applied after PUSH
    done_after = 2;
    out_word   = 32'h0000_0BEE;
    wb = wr_addr.size();
    send(16'h0100);
    @(negedge clk);
    cfg_gain = 32'd9; cfg_boost = 32'd9; cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    @(negedge clk);
    cfg_gain = 32'd5; cfg_boost = 32'd7; cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    k = 0;
    while (!bus.smp_out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("cfg_sample_out", {47'd0, bus.smp_out_valid, bus.smp_out_data}, {47'd0, 1'b1, 16'h0BEE});
    sb = cyc;
    while (cyc < sb + 3) @(negedge clk);
    chk("cfg_ready_low", {63'd0, bus.smp_in_ready}, 64'd0);
    @(negedge clk);
    chk("cfg_ready_third", {63'd0, bus.smp_in_ready}, 64'd1);
    chk("cfg_write_count", 64'(wr_addr.size() - wb), 64'd3);
    if (wr_addr.size() >= wb + 3) begin
      chk("cfg_gain_write", {27'd0, wr_addr[wb+1], wr_data[wb+1]}, {27'd0, 5'd1, 32'd5});
      chk("cfg_boost_write", {27'd0, wr_addr[wb+2], wr_data[wb+2]}, {27'd0, 5'd2, 32'd7});
      chk("cfg_gain_cycle", 64'(wr_cyc[wb+1] - sb), 64'd2);
      chk("cfg_boost_cycle", 64'(wr_cyc[wb+2] - sb), 64'd3);
    end

    // Backpressure: smp_out_ready low for 20 cycles
    done_after = 1;
    out_word   = 32'h0000_C0DE;
    bus.smp_out_ready = 1'b0;
    send(16'h0042);
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd6);
    held = bus.smp_out_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.smp_out_valid || bus.smp_out_data !== held || bus.smp_in_ready) stable = 1'b0;
    end
    chk("bp_hold_stable", {63'd0, stable}, 64'd1);
    chk("bp_data", 64'(held), 64'hC0DE);
    bus.smp_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {62'd0, bus.smp_out_valid, busy}, 64'd0);

    // Reset during WAIT_STAT with a config update pending
    done_after = 1000;
    send(16'h0777);
    @(negedge clk);
    cfg_gain = 32'h11; cfg_boost = 32'h22; cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    @(negedge clk);
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_after = 1;
    out_word   = 32'h0000_0042;
    wb = wr_addr.size();
    send(16'h0042);
    wait_out(lat);
    chk("rst_after_latency", 64'(lat), 64'd6);
    chk("rst_no_cfg_write", 64'(wr_addr.size() - wb), 64'd1);
    if (wr_addr.size() > wb)
      chk("rst_first_write", 64'(wr_addr[wb]), 64'd6);
    @(negedge clk);

`ifdef GFX_SEQ_BYPASS_EN
    bypass = 1'b1;
    wb = wr_addr.size();
    sb = stat_reads;
    send(16'h1234);
    wait_out(lat);
    chk("byp_latency", 64'(lat), 64'd1);
    chk("byp_data", 64'(bus.smp_out_data), 64'h1234);
    chk("byp_no_bus", {32'd0, 64'(wr_addr.size() - wb) + 64'(stat_reads - sb)}, 64'd0);
    @(negedge clk);
    bypass = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/gfx_effect_sequencer.md
# gfx_effect_sequencer

Avalon-MM master that drives the guitar effect register block on a per-sample basis: it writes each incoming audio sample to the effect's input register, polls the status register until processing completes, reads the output register and delivers the result on a ready/valid stream. It also applies gain and boost updates between samples, so the effect is never reconfigured while a sample is in flight. It sits between the audio codec sample path and the effect's register port, in place of software polling.

## Interface

- SAMPLE_W, 16, audio sample width; sign-extended to 32 bits on the bus
- POLL_LIMIT, 255, maximum status reads per sample before timeout
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- smp_in_valid / smp_in_ready  in / out  1  input sample handshake
- smp_in_data  in  SAMPLE_W  signed input sample
- smp_out_valid / smp_out_ready  out / in  1  output sample handshake
- smp_out_data  out  SAMPLE_W  processed sample, readdata[SAMPLE_W-1:0]
- cfg_update  in  1  one-cycle pulse; latch cfg_gain / cfg_boost
- cfg_gain, cfg_boost  in  32  new distortion gain / boost
- err_clr  in  1  clears timeout_err
- avm_address  out  5  effect register address
- avm_write, avm_read  out  1  single-cycle strobes, never both high
- avm_writedata  out  32  write data
- avm_readdata  in  32  valid the cycle after avm_read
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky, set on poll timeout

## Operation

- Register map: GAIN=1, BOOST=2, STATUS=3, OUTPUT=5, INPUT=6; STATUS bit 0 = done.
- States: IDLE, CFG_GAIN, CFG_BOOST, WR_IN, RD_STAT, WAIT_STAT, RD_OUT, WAIT_OUT, PUSH.
- cfg_update copies cfg_gain/cfg_boost into shadow registers and sets cfg_pending, in any state. A second pulse before the update is applied overwrites the shadows; the latest value wins.
- IDLE: if cfg_pending, go CFG_GAIN -> CFG_BOOST, one write each, then clear pending and return to IDLE. Otherwise smp_in_ready=1; on handshake, latch the sample and go WR_IN.
- cfg_update arriving in the same cycle as a sample handshake: the sample is accepted, and the configuration is applied after that sample is pushed.
- WR_IN: write sign-extended sample to INPUT, then go RD_STAT.
- RD_STAT issues a read; WAIT_STAT captures readdata. If done, go RD_OUT. Otherwise increment the poll count; on reaching POLL_LIMIT, set timeout_err, drop the sample and go IDLE. Otherwise go back to RD_STAT.
- RD_OUT / WAIT_OUT: read OUTPUT and capture the low SAMPLE_W bits into the output register.
- PUSH: smp_out_valid=1 and data held stable until smp_out_ready; then go IDLE.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- Reset mid-operation: avm strobes drop immediately (asynchronous), any in-flight sample is lost, and shadow registers and pending are cleared.

## Timing

- Reset values: all outputs 0, state IDLE, poll count 0.
- Input accepted at cycle 0 with done on first poll: WR_IN at 1, RD_STAT 2, WAIT_STAT 3, RD_OUT 4, WAIT_OUT 5, smp_out_valid at cycle 6.
- Each extra poll adds 2 cycles.
- Configuration update: 2 bus cycles; next smp_in_ready at the third cycle.
- Throughput is at most one sample per 7 cycles; smp_in_ready is low whenever busy.

## Configuration

- GFX_SEQ_BYPASS_EN defined: adds input port bypass (1 bit).
  - With bypass=1, IDLE routes an accepted sample straight to PUSH unchanged, with no bus access; smp_out_valid appears 1 cycle after accept.
  - Pending configuration is still applied first.
- Undefined: no bypass port; every sample goes through the effect.

## Structure

- Shared package gfx_pkg holds:
  - register address constants
  - STATUS_DONE_BIT
  - the state enum
- One sub-module, gfx_poll_counter: a clearable counter with terminal flag at POLL_LIMIT, sized $clog2(POLL_LIMIT+1).

## Test plan

- Reset then sample 0x8001 with status done on first read -> writes INPUT 0xFFFF8001; smp_out_valid at cycle 6 with readdata[15:0].
- Status done on third read -> valid at cycle 10; exactly 3 STATUS reads issued.
- Status never done with POLL_LIMIT=4 -> 4 reads, then timeout_err=1, no output, IDLE; err_clr clears it.
- cfg_update (gain=5, boost=7) mid-sample -> writes addr 1 = 5, then addr 2 = 7, only after PUSH completes. Two pulses before application -> only the last values are written.
- smp_out_ready held low 20 cycles -> data stable, smp_in_ready low throughout; reset asserted during WAIT_STAT -> all outputs 0 immediately.
- With GFX_SEQ_BYPASS_EN and bypass=1 -> sample 0x1234 out 1 cycle later; avm_read and avm_write stay 0.
